// File: rtl/mp_coeff_loader.sv
// Coefficient loader for the memory-polynomial LUT bank: streams 32-bit words into a
// selected LUT range through a BRAM-style write port and holds DPD off while tables change.
//
// state | meaning
// IDLE  | waiting for start_i; stream not ready
// LOAD  | accepting words, one write per handshake
// DONE  | one-cycle tail after the last write; done_o follows
module mp_coeff_loader #(
  parameter int M          = 3,
  parameter int LUT_num    = M + 1,
  parameter int RESOLUTION = 4096,
  localparam int CW = $clog2(RESOLUTION),
  localparam int LW = $clog2(LUT_num),
  localparam int AW = CW + LW + 2
) (
  input  logic          AXI_clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [LW-1:0] lut_first_i,
  input  logic [LW-1:0] lut_last_i,
  input  logic          abort_i,
  input  logic [31:0]   s_tdata_i,
  input  logic          s_tvalid_i,
  input  logic          s_tlast_i,
  output logic          s_tready_o,
  output logic [31:0]   coeff_o,
  output logic [AW-1:0] coeff_addr_o,
  output logic          coeff_en_o,
  input  logic          dpd_en_i,
  output logic          dpd_en_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [LW-1:0] LUT_MAX = LW'(LUT_num - 1);
  localparam logic [CW-1:0] ENT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LW-1:0] lut_cnt_q, lut_cnt_d;
  logic [CW-1:0] ent_cnt_q, ent_cnt_d;
  logic [LW-1:0] last_q, last_d;

  logic [31:0]   coeff_q, coeff_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          en_q, en_d;
  logic          tready_q, tready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          dpd_q, dpd_d;

  logic range_ok;
  logic start_ok;
  logic start_bad;
  logic in_load;
  logic abort_hit;
  logic wr;
  logic final_word;

  assign range_ok   = (lut_first_i <= lut_last_i) && (lut_last_i <= LUT_MAX);
  assign start_ok   = (state_q == S_IDLE) && start_i && range_ok;
  assign start_bad  = (state_q == S_IDLE) && start_i && !range_ok;
  assign in_load    = (state_q == S_LOAD);
  assign abort_hit  = in_load && abort_i;
  // Abort wins over a word presented in the same cycle.
  assign wr         = in_load && s_tvalid_i && tready_q && !abort_i;
  assign final_word = (lut_cnt_q == last_q) && (ent_cnt_q == ENT_MAX);

  always_ff @(posedge AXI_clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_hit) begin
          state_d = S_IDLE;
        end else if (wr && (final_word || s_tlast_i)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    lut_cnt_d = lut_cnt_q;
    ent_cnt_d = ent_cnt_q;
    last_d    = last_q;
    coeff_d   = coeff_q;
    addr_d    = addr_q;
    en_d      = 1'b0;
    err_d     = err_q;

    if (start_ok) begin
      lut_cnt_d = lut_first_i;
      ent_cnt_d = '0;
      last_d    = lut_last_i;
      err_d     = 1'b0;
    end

    if (start_bad || abort_hit) begin
      err_d = 1'b1;
    end

    if (wr) begin
      en_d      = 1'b1;
      coeff_d   = s_tdata_i;
      addr_d    = {lut_cnt_q, ent_cnt_q, 2'b00};
      ent_cnt_d = ent_cnt_q + CW'(1);
      if (ent_cnt_q == ENT_MAX) begin
        lut_cnt_d = lut_cnt_q + LW'(1);
      end
      // Framing error: tlast missing on the final word, or present on an earlier one.
      if (final_word != s_tlast_i) begin
        err_d = 1'b1;
      end
    end

    tready_d = (state_d == S_LOAD);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_q == S_DONE) || start_bad;
    dpd_d    = dpd_en_i && !busy_q && !err_q;
  end

  always_ff @(posedge AXI_clk_i) begin
    if (reset_i) begin
      lut_cnt_q <= '0;
      ent_cnt_q <= '0;
      last_q    <= '0;
      coeff_q   <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dpd_q     <= 1'b0;
    end else begin
      lut_cnt_q <= lut_cnt_d;
      ent_cnt_q <= ent_cnt_d;
      last_q    <= last_d;
      coeff_q   <= coeff_d;
      addr_q    <= addr_d;
      en_q      <= en_d;
      tready_q  <= tready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      dpd_q     <= dpd_d;
    end
  end

  assign s_tready_o   = tready_q;
  assign coeff_o      = coeff_q;
  assign coeff_addr_o = addr_q;
  assign coeff_en_o   = en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign dpd_en_o     = dpd_q;

endmodule

// File: tb/tb_mp_coeff_loader.sv
// Bench for mp_coeff_loader: a driver pushes expected LUT writes into a queue, a monitor
// pops and compares them on coeff_en_o; framing, done, error and DPD gating are checked inline.
module tb_mp_coeff_loader;
  localparam int M   = 3;
  localparam int NL  = M + 1;
  localparam int RES = 16;
  localparam int LW  = 2;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          start_i = 1'b0;
  logic [LW-1:0] lut_first_i = '0;
  logic [LW-1:0] lut_last_i = '0;
  logic          abort_i = 1'b0;
  logic [31:0]   s_tdata_i = '0;
  logic          s_tvalid_i = 1'b0;
  logic          s_tlast_i = 1'b0;
  logic          dpd_en_i = 1'b1;
  logic          s_tready_o;
  logic [31:0]   coeff_o;
  logic [AW-1:0] coeff_addr_o;
  logic          coeff_en_o;
  logic          dpd_en_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  mp_coeff_loader #(.M(M), .RESOLUTION(RES)) dut (
    .AXI_clk_i   (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .lut_first_i (lut_first_i),
    .lut_last_i  (lut_last_i),
    .abort_i     (abort_i),
    .s_tdata_i   (s_tdata_i),
    .s_tvalid_i  (s_tvalid_i),
    .s_tlast_i   (s_tlast_i),
    .s_tready_o  (s_tready_o),
    .coeff_o     (coeff_o),
    .coeff_addr_o(coeff_addr_o),
    .coeff_en_o  (coeff_en_o),
    .dpd_en_i    (dpd_en_i),
    .dpd_en_o    (dpd_en_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write the DUT issues must match the oldest expected write, in the right cycle.
  always @(negedge clk) begin
    if (coeff_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write (cycle %0d)",
                 coeff_addr_o, coeff_o, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        chk("wr_addr", 64'(coeff_addr_o), 64'(e.addr));
        chk("wr_data", 64'(coeff_o), 64'(e.data));
      end
    end
    if (done_o === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_flags"}, 64'({coeff_en_o, busy_o, done_o, err_o, dpd_en_o, s_tready_o}), 64'd0);
    chk({name, "_data"}, 64'(coeff_o), 64'd0);
    chk({name, "_addr"}, 64'(coeff_addr_o), 64'd0);
  endtask

  // One load. Word k of the range lands at byte address (first*RES + k)*4.
  task automatic do_load(input int first, input int last, input int stop_at, input bit final_tlast,
                         input bit rand_bp, input bit seq_data, input int abort_after,
                         input int reset_after, input bit poke);
    int n_tot, n, k, done0;
    bit exp_err, v, dpd_checked;
    logic [31:0] d;
    n_tot = (last - first + 1) * RES;
    if (abort_after >= 0) n = abort_after;
    else if (reset_after >= 0) n = reset_after;
    else if (stop_at >= 0) n = stop_at + 1;
    else n = n_tot;
    exp_err = (stop_at >= 0) ? (stop_at < n_tot - 1) : !final_tlast;
    done0 = done_cnt;

    start_i = 1'b1;
    lut_first_i = first[LW-1:0];
    lut_last_i = last[LW-1:0];
    step();
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
    chk("tready_after_start", 64'(s_tready_o), 64'd1);

    k = 0;
    dpd_checked = 1'b0;
    while (k < n) begin
      v = rand_bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_tvalid_i = v;
      s_tlast_i = 1'b0;
      start_i = poke && (k == 10);
      if (start_i) begin
        lut_first_i = 2'd3;
        lut_last_i = 2'd3;
      end
      if (v) begin
        d = seq_data ? 32'(k) : $urandom;
        s_tdata_i = d;
        s_tlast_i = (k == n - 1) && (abort_after < 0) && (reset_after < 0) &&
                    ((stop_at >= 0) || final_tlast);
        exp_q.push_back('{addr: AW'((first * RES + k) * 4), data: d, cyc: cyc + 1});
        k++;
      end
      step();
      if (!dpd_checked) begin
        chk("dpd_gated_in_load", 64'(dpd_en_o), 64'd0);
        dpd_checked = 1'b1;
      end
    end
    s_tvalid_i = 1'b0;
    s_tlast_i = 1'b0;
    start_i = 1'b0;

    if (abort_after >= 0) begin
      abort_i = 1'b1;
      s_tvalid_i = 1'b1;
      s_tdata_i = $urandom;
      step();
      abort_i = 1'b0;
      s_tvalid_i = 1'b0;
      chk("abort_busy", 64'(busy_o), 64'd0);
      chk("abort_tready", 64'(s_tready_o), 64'd0);
      chk("abort_no_write", 64'(coeff_en_o), 64'd0);
      chk("abort_err", 64'(err_o), 64'd1);
      repeat (4) step();
      chk("abort_no_done", 64'(done_cnt), 64'(done0));
      chk("abort_dpd", 64'(dpd_en_o), 64'd0);
    end else if (reset_after >= 0) begin
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      chk_all_zero("midload_reset");
      step();
      chk("post_reset_dpd", 64'(dpd_en_o), 64'd1);
      chk("post_reset_no_done", 64'(done_cnt), 64'(done0));
    end else begin
      chk("busy_in_done", 64'(busy_o), 64'd1);
      chk("done_early", 64'(done_o), 64'd0);
      step();
      chk("done_pulse", 64'(done_o), 64'd1);
      chk("done_busy", 64'(busy_o), 64'd0);
      chk("done_tready", 64'(s_tready_o), 64'd0);
      chk("load_err", 64'(err_o), 64'(exp_err));
      step();
      chk("done_one_cycle", 64'(done_o), 64'd0);
      chk("dpd_after_load", 64'(dpd_en_o), 64'(!exp_err));
    end
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic bad_start(input int first, input int last);
    start_i = 1'b1;
    lut_first_i = first[LW-1:0];
    lut_last_i = last[LW-1:0];
    step();
    start_i = 1'b0;
    chk("bad_err", 64'(err_o), 64'd1);
    chk("bad_done", 64'(done_o), 64'd1);
    chk("bad_busy", 64'(busy_o), 64'd0);
    chk("bad_tready", 64'(s_tready_o), 64'd0);
    step();
    chk("bad_done_once", 64'(done_o), 64'd0);
    chk("bad_dpd", 64'(dpd_en_o), 64'd0);
    repeat (2) step();
    chk("bad_no_write", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int first, last;
    bit bp, ftl;
    repeat (3) step();
    chk_all_zero("reset");
    reset_i = 1'b0;
    step();
    chk("dpd_idle", 64'(dpd_en_o), 64'd1);

    // full load, data = index, start pulse mid-load must be ignored
    do_load(0, NL - 1, -1, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1);
    dpd_en_i = 1'b0;
    step();
    chk("dpd_follows_low", 64'(dpd_en_o), 64'd0);
    dpd_en_i = 1'b1;
    step();
    chk("dpd_follows_high", 64'(dpd_en_o), 64'd1);

    // single LUT with backpressure
    do_load(2, 2, -1, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0);
    // early tlast on word 5
    do_load(0, 1, 5, 1'b1, 1'b0, 1'b0, -1, -1, 1'b0);
    repeat (3) step();
    chk("dpd_held_off", 64'(dpd_en_o), 64'd0);
    // invalid range
    bad_start(3, 1);
    // abort after 7 words, then a clean load clears the error
    do_load(0, 3, -1, 1'b1, 1'b0, 1'b0, 7, -1, 1'b0);
    do_load(1, 1, -1, 1'b1, 1'b1, 1'b0, -1, -1, 1'b0);
    // reset after 3 words
    do_load(0, 2, -1, 1'b1, 1'b0, 1'b0, -1, 3, 1'b0);

    for (int i = 0; i < 6; i++) begin
      first = int'($urandom_range(0, NL - 1));
      last = int'($urandom_range(first, NL - 1));
      bp = ($urandom_range(0, 1) == 1);
      ftl = ($urandom_range(0, 3) != 0);
      do_load(first, last, -1, ftl, bp, 1'b0, -1, -1, 1'b0);
    end
    bad_start(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
